// File: rtl/capture_pkg.sv
// Shared types and constants for the capture/dump path.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    WAIT_TX,
    FIN
  } dump_state_t;

  localparam logic [5:0] DUMP_HDR_TAG  = 6'b101010;
  localparam int         DEFAULT_DEPTH = 512;

endpackage

// File: rtl/dump_addr_gen.sv
// Trace read-address generator: latches the oldest-sample address, counts
// samples and flags the final one; addresses wrap modulo DEPTH.
module dump_addr_gen
  import capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] trace_end,
  input  logic          advance,
  output logic [AW-1:0] raddr,
  output logic          last
);

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] start_q, start_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    start_d = start_q;
    cnt_d   = cnt_q;
    if (start) begin
      start_d = trace_end;
      cnt_d   = '0;
    end else if (advance) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      start_q <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  // AW-bit sum drops the carry, which is exactly the modulo-DEPTH wrap.
  assign raddr = start_q + cnt_q[AW-1:0];
  assign last  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/channel_dump.sv
// Streams one channel's captured trace from sample RAM to the UART, oldest first.
// Define CHANNEL_DUMP_HDR_EN to prefix each dump with a {tag, channel} header byte.
module channel_dump
  import capture_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = 9,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump,
  input  logic [1:0]    ch_sel,
  input  logic [AW-1:0] trace_end,
  input  logic [7:0]    rdata,
  input  logic          tx_done,
  output logic [AW-1:0] raddr,
  output logic          ren,
  output logic [1:0]    ch_ram_sel,
  output logic [7:0]    tx_data,
  output logic          trmt,
  output logic          busy,
  output logic          dump_fin
);

  dump_state_t state_q, state_d;
  logic [1:0]  lat_q, lat_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ren_q, ren_d;
  logic        trmt_q, trmt_d;
  logic        busy_q, busy_d;
  logic        fin_q, fin_d;
  logic        start, advance, last, hdr_pend;

`ifdef CHANNEL_DUMP_HDR_EN
  logic hdr_q, hdr_d;
  assign hdr_pend = hdr_q;
`else
  assign hdr_pend = 1'b0;
`endif

  assign start   = (state_q == IDLE) && dump;
  assign advance = (state_q == WAIT_TX) && tx_done && !last && !hdr_pend;

  dump_addr_gen #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .trace_end (trace_end),
    .advance   (advance),
    .raddr     (raddr),
    .last      (last)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    sel_d     = sel_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    ren_d     = 1'b0;
    trmt_d    = 1'b0;
    fin_d     = 1'b0;
`ifdef CHANNEL_DUMP_HDR_EN
    hdr_d     = hdr_q;
`endif
    case (state_q)
      IDLE: begin
        if (dump) begin
          sel_d  = (ch_sel == 2'd3) ? 2'd0 : ch_sel;
          busy_d = 1'b1;
`ifdef CHANNEL_DUMP_HDR_EN
          hdr_d     = 1'b1;
          tx_data_d = {DUMP_HDR_TAG, sel_d};
          trmt_d    = 1'b1;
          state_d   = SEND;
`else
          ren_d   = 1'b1;
          state_d = RD;
`endif
        end
      end
      RD: begin
        lat_d   = 2'd1;
        state_d = LAT;
      end
      // lat_q counts clocks since ren; rdata is valid when it reaches RD_LAT.
      LAT: begin
        if (lat_q == 2'(RD_LAT)) begin
          tx_data_d = rdata;
          trmt_d    = 1'b1;
          state_d   = SEND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          if (hdr_pend || !last) begin
            ren_d   = 1'b1;
            state_d = RD;
          end else begin
            fin_d   = 1'b1;
            state_d = FIN;
          end
`ifdef CHANNEL_DUMP_HDR_EN
          hdr_d = 1'b0;
`endif
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      sel_q     <= '0;
      tx_data_q <= '0;
      ren_q     <= 1'b0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
`ifdef CHANNEL_DUMP_HDR_EN
      hdr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      sel_q     <= sel_d;
      tx_data_q <= tx_data_d;
      ren_q     <= ren_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
`ifdef CHANNEL_DUMP_HDR_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  assign ren        = ren_q;
  assign ch_ram_sel = sel_q;
  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign busy       = busy_q;
  assign dump_fin   = fin_q;

endmodule

// File: tb/tb_channel_dump.sv
// Bench for channel_dump: two instances (RD_LAT 1 and 3) against a RAM/UART
// model and a trace-order reference model.
module tb_channel_dump;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
`ifdef CHANNEL_DUMP_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL  = DEPTH + HDR;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          dump;
  logic [1:0]    ch_sel;
  logic [AW-1:0] trace_end;

  logic [1:0]          ren_w, trmt_w, busy_w, fin_w, tx_done_w;
  logic [1:0][1:0]     bank_w;
  logic [1:0][7:0]     tx_data_w, rdata_w;
  logic [1:0][AW-1:0]  raddr_w;

  logic [7:0] ram [0:2][0:DEPTH-1];
  int cur_te = 0;
  int cur_ch = 0;
  int total  = 0;
  int bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: byte k of a dump is the header (if enabled) followed by the
  // trace read oldest-first from cur_te, wrapping modulo DEPTH.
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] hb;
    hb = {6'b101010, 2'(cur_ch)};
    if (HDR == 1 && k == 0) return hb;
    return ram[cur_ch][(cur_te + k - HDR) % DEPTH];
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int RL = (gi == 0) ? 1 : 3;

    logic [2:0] v_pipe = 3'b000;
    logic [7:0] d_pipe [0:2];
    logic [7:0] junk = 8'h00;
    int         gap  = 0;
    logic       tx_done_r = 1'b0;
    int         sent_cnt = 0;
    int         fin_cnt  = 0;
    int         since    = 0;
    logic [7:0] last_tx  = 8'h00;
    bit         fin_prev = 1'b0;

    channel_dump #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .RD_LAT (RL)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst),
      .dump       (dump),
      .ch_sel     (ch_sel),
      .trace_end  (trace_end),
      .rdata      (rdata_w[gi]),
      .tx_done    (tx_done_w[gi]),
      .raddr      (raddr_w[gi]),
      .ren        (ren_w[gi]),
      .ch_ram_sel (bank_w[gi]),
      .tx_data    (tx_data_w[gi]),
      .trmt       (trmt_w[gi]),
      .busy       (busy_w[gi]),
      .dump_fin   (fin_w[gi])
    );

    // RAM: data valid exactly RL clocks after ren, garbage otherwise.
    assign rdata_w[gi]   = v_pipe[RL-1] ? d_pipe[RL-1] : junk;
    assign tx_done_w[gi] = tx_done_r;

    always @(posedge clk) begin
      v_pipe    <= {v_pipe[1:0], ren_w[gi]};
      d_pipe[0] <= ram[bank_w[gi]][raddr_w[gi]];
      d_pipe[1] <= d_pipe[0];
      d_pipe[2] <= d_pipe[1];
      junk      <= 8'($urandom);
      if (rst) begin
        gap       <= 0;
        tx_done_r <= 1'b0;
      end else begin
        tx_done_r <= 1'b0;
        if (trmt_w[gi]) begin
          gap <= $urandom_range(1, 5);
        end else if (gap > 0) begin
          gap <= gap - 1;
          if (gap == 1) tx_done_r <= 1'b1;
        end
      end
    end

    initial begin : mon
      forever begin
        @(negedge clk);
        since++;
        if (rst) begin
          sent_cnt = 0;
          fin_prev = 1'b0;
        end else begin
          if (fin_prev) check("busy_after_fin", busy_w[gi], 0);
          fin_prev = fin_w[gi];
          if (busy_w[gi]) check("bank_sel", bank_w[gi], cur_ch);
          if (trmt_w[gi]) begin
            check("tx_byte", tx_data_w[gi], exp_byte(sent_cnt));
            if (!(HDR == 1 && sent_cnt == 0)) check("ren_to_trmt", since, RL + 1);
            last_tx = tx_data_w[gi];
            sent_cnt++;
          end
          if (ren_w[gi]) begin
            check("raddr", raddr_w[gi], (cur_te + sent_cnt - HDR) % DEPTH);
            since = 0;
          end
          if (tx_done_w[gi]) check("tx_hold", tx_data_w[gi], last_tx);
          if (fin_w[gi]) begin
            check("fin_bytes", sent_cnt, TOTAL);
            check("busy_at_fin", busy_w[gi], 1);
            fin_cnt++;
            sent_cnt = 0;
          end
        end
      end
    end
  end

  task automatic start_dump(input int te, input int ch);
    cur_te = te;
    cur_ch = (ch == 3) ? 0 : ch;
    @(negedge clk);
    dump      = 1'b1;
    ch_sel    = 2'(ch);
    trace_end = AW'(te);
    @(negedge clk);
    dump = 1'b0;
  endtask

  // mode 1: re-pulse dump and switch ch_sel to 2 at byte 100 (must be ignored).
  task automatic run_dump(input int te, input int ch, input int mode);
    int f0, f1, n, t;
    f0 = g_inst[0].fin_cnt;
    f1 = g_inst[1].fin_cnt;
    start_dump(te, ch);
    n = 0;
    t = 0;
    while ((g_inst[0].fin_cnt == f0 || g_inst[1].fin_cnt == f1) && n < BUDGET) begin
      @(negedge clk);
      n++;
      trace_end = AW'($urandom);
      if (trmt_w[0]) t++;
      if (mode == 1 && t == 100 && trmt_w[0]) begin
        dump   = 1'b1;
        ch_sel = 2'd2;
      end else begin
        dump = 1'b0;
      end
    end
    dump = 1'b0;
    check("dump_timeout", n < BUDGET, 1);
    repeat (20) @(negedge clk);
    check("fin_once_lat1", g_inst[0].fin_cnt, f0 + 1);
    check("fin_once_lat3", g_inst[1].fin_cnt, f1 + 1);
    check("idle_busy", busy_w, 2'b00);
    $display("dump te=%0d ch=%0d mode=%0d fins=%0d/%0d checks=%0d", te, ch, mode,
             g_inst[0].fin_cnt, g_inst[1].fin_cnt, total);
  endtask

  initial begin
    int n, t, cnt;
    rst       = 1'b1;
    dump      = 1'b0;
    ch_sel    = 2'd0;
    trace_end = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[0][i] = 8'(i);
      ram[1][i] = 8'($urandom);
      ram[2][i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy_w[i], 0);
      check("rst_trmt", trmt_w[i], 0);
      check("rst_ren", ren_w[i], 0);
      check("rst_fin", fin_w[i], 0);
      check("rst_tx_data", tx_data_w[i], 0);
      check("rst_raddr", raddr_w[i], 0);
      check("rst_bank", bank_w[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_dump(0, 0, 0);
    run_dump(DEPTH - 1, 0, 0);
    run_dump($urandom_range(0, DEPTH - 1), 3, 0);
    run_dump($urandom_range(0, DEPTH - 1), 0, 1);

    // Reset while instance 0 waits on byte 37's tx_done.
    start_dump($urandom_range(0, DEPTH - 1), 1);
    n = 0;
    t = 0;
    while (t < 38 && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (trmt_w[0]) t++;
    end
    check("reach_byte37", t, 38);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy_w, 2'b00);
    check("abort_trmt", trmt_w, 2'b00);
    check("abort_fin", fin_w, 2'b00);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(trmt_w[0]) + int'(trmt_w[1]) + int'(fin_w[0]) + int'(fin_w[1]);
    end
    check("abort_quiet", cnt, 0);
    $display("reset abort after byte 37, quiet=%0d", cnt);

    run_dump($urandom_range(0, DEPTH - 1), 1, 0);
    run_dump($urandom_range(0, DEPTH - 1), 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/channel_dump.md
Name: channel_dump

Overview:
- Downstream stage of the capture controller. On a dump request it reads one channel's captured trace out of sample RAM and streams it, byte by byte, to the UART transmitter.
- Reads oldest-to-newest, starting at the trace end latched when capture finished. Wraps modulo DEPTH.
- Pulses dump_fin on completion so the capture FSM can leave its DUMP state.

Parameters:
- DEPTH, 512, samples per channel trace; must be a power of 2.
- AW, 9, RAM address width; equals log2(DEPTH).
- RD_LAT, 1, RAM read latency in clocks from ren to valid rdata; legal values 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-high (1 = reset)
- dump  in  1  start request; sampled only in IDLE
- ch_sel  in  2  channel to dump (0..2); 3 = reserved, treated as 0
- trace_end  in  AW  address of the oldest sample; latched at start
- rdata  in  8  RAM read data, valid RD_LAT clocks after ren
- tx_done  in  1  UART byte sent; single-cycle pulse
- raddr  out  AW  RAM read address
- ren  out  1  RAM read enable; one-cycle pulse per sample
- ch_ram_sel  out  2  RAM bank select; holds latched ch_sel while busy
- tx_data  out  8  byte to UART; stable from trmt until tx_done
- trmt  out  1  UART transmit strobe; one-cycle pulse
- busy  out  1  high from the start cycle through the dump_fin cycle
- dump_fin  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-dump aborts immediately, with no dump_fin and no further trmt.
- States: IDLE, RD, LAT, SEND, WAIT_TX, FIN.
- IDLE: when dump=1, latch start address := trace_end, latch ch_sel, clear smpl_cnt, set busy, go to RD.
- RD: ren=1 with raddr = start address + smpl_cnt (mod DEPTH, truncated to AW bits). Go to LAT.
- LAT: wait RD_LAT clocks from ren (counter). Capture rdata into tx_data on the clock rdata is valid. Go to SEND.
- SEND: trmt=1 for one cycle. Go to WAIT_TX.
- WAIT_TX: hold until tx_done.
  - smpl_cnt = DEPTH-1: go to FIN.
  - Otherwise increment smpl_cnt and go to RD.
- FIN: dump_fin=1 for one cycle. busy clears the next cycle. Go to IDLE.
- smpl_cnt is AW+1 bits wide and counts 0..DEPTH-1, so exactly DEPTH bytes are sent per dump.
- Wrap: trace_end=DEPTH-1 gives read order DEPTH-1, 0, 1, …, DEPTH-2.
- dump while busy is ignored; it is not queued.
- tx_done outside WAIT_TX is ignored.
- tx_done in the same cycle as trmt cannot occur because the UART needs at least 1 clock; WAIT_TX samples tx_done from the cycle after SEND.
- Per-byte minimum latency is RD_LAT+3 clocks plus the UART time.
- trace_end and ch_sel changing during a dump have no effect.

Optional Feature:
- Macro CHANNEL_DUMP_HDR_EN.
- Defined:
  - After the start cycle, send a header byte {6'b101010, ch_sel} via SEND/WAIT_TX (no RAM read) before the first sample.
  - Total bytes per dump = DEPTH+1.
  - busy and dump_fin timing extend accordingly.
- Undefined: no header; exactly DEPTH bytes.

Decomposition:
- Package capture_pkg holds:
  - the dump_state_t enum (IDLE, RD, LAT, SEND, WAIT_TX, FIN) as logic [2:0];
  - localparams DUMP_HDR_TAG = 6'b101010 and DEFAULT_DEPTH = 512.
- One sub-module, dump_addr_gen: owns the start-address latch, smpl_cnt, wrap arithmetic, and the last-sample flag. The top level keeps the FSM and the UART handshake.

Test Plan:
- trace_end=0, RAM[i]=i, tx_done 4 clocks after each trmt -> bytes 0x00..0xFF, 0x00..0xFF in order (512 bytes), then one dump_fin pulse; busy low the following cycle.
- trace_end=511, RAM[i]=i[7:0] -> first bytes 0xFF, 0x00, 0x01; last byte 0xFE; exactly 512 trmt pulses.
- dump re-pulsed at byte 100 and ch_sel changed 0->2 mid-dump -> ignored; ch_ram_sel stays 0; no restart; single dump_fin.
- rst_n=1 for one cycle during WAIT_TX of byte 37 -> next cycle busy=0, trmt=0, no dump_fin; a new dump afterwards restarts from the freshly latched trace_end.
- RD_LAT=3 instance -> tx_data equals RAM[raddr] sampled exactly 3 clocks after ren; trmt never precedes valid data.
- With CHANNEL_DUMP_HDR_EN and ch_sel=2 -> first byte 0xAA, then 512 samples, then dump_fin (513 trmt pulses total).
